count_sched: RTL and testbench
==============================

Name: count_sched

Overview:
- Sequencing controller for an 8-bit up-counter datapath.
- Owns the count register. Adds load, start, stop and pause control, a prescaled count tick, terminal-count compare, and one-shot or periodic reload.
- Raises a sticky interrupt toward the ALU-level control logic.
- Sits between software-visible control strobes and the counter bank; replaces a free-running counter where bounded or periodic counting is needed.

Parameters:
- WIDTH, 8, count / load / terminal width.
- PRESCALE, 1, clk cycles per count tick (legal range 1..256).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  load load_val and begin counting
- stop  input  1  abort to IDLE
- pause  input  1  level; freezes counting while high in RUN/HOLD
- mode  input  1  0 = one-shot, 1 = periodic; sampled on each terminal event
- load_val  input  WIDTH  value loaded on start / periodic reload
- term_val  input  WIDTH  terminal count value
- irq_ack  input  1  clears done_irq and overrun
- count  output  WIDTH  current count register
- busy  output  1  high in RUN or HOLD
- done_irq  output  1  sticky terminal-count interrupt
- overrun  output  1  sticky: terminal event while done_irq already set
- wrap  output  1  one-cycle pulse on count transition all-ones -> 0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, prescaler=0.
  - busy=0, done_irq=0, overrun=0, wrap=0.
  - Reset asserted mid-run aborts immediately; no interrupt is generated.
- States: IDLE, RUN, HOLD, DONE. busy = (state==RUN or HOLD), registered from state.
- Control priority per edge: stop > start > pause > tick.
- stop=1 in any state:
  - next state is IDLE; count holds; prescaler clears.
  - done_irq and overrun are unchanged.
- start=1 (with stop=0) in any state:
  - count <= load_val, prescaler <= 0, next state is RUN.
  - In RUN/HOLD this restarts the count; no terminal event is generated.
- RUN with pause=1: next state is HOLD; count and prescaler frozen.
- HOLD with pause=0: next state is RUN; prescaler resumes from its frozen value.
- Tick generation:
  - Tick is asserted in RUN with pause=0 when prescaler==PRESCALE-1.
  - On a tick the prescaler wraps to 0; otherwise it increments.
  - PRESCALE=1 means a tick on every RUN cycle.
- On tick, if count==term_val (terminal event):
  - done_irq <= 1.
  - If done_irq was already 1, overrun <= 1.
  - mode=0: next state is DONE; count holds term_val.
  - mode=1: count <= load_val; state stays RUN.
- On tick, if count!=term_val:
  - count <= count+1 modulo 2^WIDTH.
  - If count was all-ones, wrap=1 for exactly one cycle.
  - load_val > term_val is legal: the count passes through the wrap.
- DONE: count holds, busy=0; leaves DONE only on start or stop.
- IDLE: count holds its last value.
- irq_ack=1 clears done_irq and overrun next edge. If a terminal event falls in the same cycle, set wins (done_irq stays 1); overrun takes the pre-clear done_irq value.
- Latency (PRESCALE=1):
  - start sampled at edge E0 -> count=load_val after E0.
  - Increment at each following edge.
  - Terminal event at the edge where count==term_val is sampled; done_irq high after that edge.
  - Total: term_val-load_val+1 edges after E0 (mod 2^WIDTH).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then one-shot: mode=0, load_val=0, term_val=3, PRESCALE=1, pulse start at E0 -> count 0,1,2,3 after E0..E3; after E4 done_irq=1, busy=0, state DONE, count=3 held.
- Periodic + prescale: PRESCALE=4, mode=1, load_val=10, term_val=12, start -> count steps every 4 clk: 10,11,12,10,...; done_irq set at first terminal; overrun=1 at second terminal without irq_ack.
- Wrap: mode=0, load_val=254, term_val=1 -> count 254,255,0,1; wrap high one cycle on 255->0; done_irq after terminal tick.
- Pause/stop priority: PRESCALE=3, run from load_val=5, raise pause mid-prescale for 5 cycles -> count and prescaler frozen, busy=1; drop pause -> resumes with remaining prescale; assert stop+start together -> IDLE, count held, busy=0.
- Ack collision: periodic term reached with done_irq=1 and irq_ack=1 in the same cycle -> done_irq stays 1, overrun=1; lone irq_ack next cycle -> both 0.
- Async reset mid-RUN: drop reset between edges with count=7 -> count=0, busy=0, done_irq=0 immediately (no clock edge); release -> IDLE until start.

Source files
------------

// File: rtl/count_sched.sv
// Sequencing controller for an up-counter: load/start/stop/pause control,
// prescaled count tick, terminal-count compare with one-shot or periodic reload.
module count_sched #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done_irq,
  output logic             overrun,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Nine bits hold every prescaler value for PRESCALE up to 256.
  localparam int              PW        = 9;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRE_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [PW-1:0]    pre_r, pre_s;
  logic             done_irq_r, done_irq_s;
  logic             overrun_r, overrun_s;
  logic             wrap_r, wrap_s;
  logic             busy_r, busy_s;

  assign count    = count_r;
  assign busy     = busy_r;
  assign done_irq = done_irq_r;
  assign overrun  = overrun_r;
  assign wrap     = wrap_r;

  // Next-state, count, prescaler and interrupt logic; priority stop > start > pause > tick.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    pre_s      = pre_r;
    done_irq_s = done_irq_r;
    overrun_s  = overrun_r;
    wrap_s     = 1'b0;

    // Ack clears first so a same-cycle terminal event can override it.
    if (irq_ack) begin
      done_irq_s = 1'b0;
      overrun_s  = 1'b0;
    end else begin
      done_irq_s = done_irq_r;
      overrun_s  = overrun_r;
    end

    if (stop) begin
      state_s = IDLE;
      pre_s   = {PW{1'b0}};
    end else if (start) begin
      state_s = RUN;
      count_s = load_val;
      pre_s   = {PW{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (pause) begin
            state_s = HOLD;
          end else if (pre_r == PRE_LAST) begin
            pre_s = {PW{1'b0}};
            if (count_r == term_val) begin
              done_irq_s = 1'b1;
              if (done_irq_r) begin
                overrun_s = 1'b1;
              end else begin
                overrun_s = overrun_s;
              end
              if (mode) begin
                count_s = load_val;
              end else begin
                state_s = DONE;
              end
            end else begin
              count_s = count_r + CNT_ONE;
              wrap_s  = (count_r == ALL_ONES);
            end
          end else begin
            pre_s = pre_r + PRE_ONE;
          end
        end
        HOLD: begin
          if (pause) begin
            state_s = HOLD;
          end else begin
            state_s = RUN;
          end
        end
        IDLE:    state_s = IDLE;
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end

    busy_s = (state_s == RUN) || (state_s == HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      count_r    <= {WIDTH{1'b0}};
      pre_r      <= {PW{1'b0}};
      done_irq_r <= 1'b0;
      overrun_r  <= 1'b0;
      wrap_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      pre_r      <= pre_s;
      done_irq_r <= done_irq_s;
      overrun_r  <= overrun_s;
      wrap_r     <= wrap_s;
      busy_r     <= busy_s;
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: three instances (PRESCALE 1, 4, 3) share stimulus and
// are compared each cycle against a behavioural model, plus pinned literals.
module tb_count_sched;

  localparam int NI = 3;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_HOLD = 2;
  localparam int P_DONE = 3;

  logic       clk;
  logic       reset;
  logic       start, stop, pause, mode, irq_ack;
  logic [7:0] load_val, term_val;

  logic [7:0] cnt_o  [NI];
  logic       busy_o [NI];
  logic       irq_o  [NI];
  logic       ovr_o  [NI];
  logic       wrap_o [NI];

  int         pres [NI] = '{1, 4, 3};
  int         m_ph  [NI];
  int         m_pc  [NI];
  logic [7:0] m_cnt [NI];
  bit         m_irq [NI];
  bit         m_ovr [NI];
  bit         m_wrap[NI];

  int checks = 0;
  int errors = 0;

  count_sched #(.WIDTH(8), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .term_val(term_val), .irq_ack(irq_ack),
    .count(cnt_o[0]), .busy(busy_o[0]), .done_irq(irq_o[0]),
    .overrun(ovr_o[0]), .wrap(wrap_o[0]));

  count_sched #(.WIDTH(8), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .term_val(term_val), .irq_ack(irq_ack),
    .count(cnt_o[1]), .busy(busy_o[1]), .done_irq(irq_o[1]),
    .overrun(ovr_o[1]), .wrap(wrap_o[1]));

  count_sched #(.WIDTH(8), .PRESCALE(3)) u_p3 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .term_val(term_val), .irq_ack(irq_ack),
    .count(cnt_o[2]), .busy(busy_o[2]), .done_irq(irq_o[2]),
    .overrun(ovr_o[2]), .wrap(wrap_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_ph[k] = P_IDLE; m_pc[k] = 0; m_cnt[k] = 8'd0;
      m_irq[k] = 1'b0; m_ovr[k] = 1'b0; m_wrap[k] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model, from the inputs present at the edge.
  task automatic model_edge();
    bit nirq, novr;
    for (int k = 0; k < NI; k++) begin
      nirq = m_irq[k];
      novr = m_ovr[k];
      m_wrap[k] = 1'b0;
      if (irq_ack) begin
        nirq = 1'b0;
        novr = 1'b0;
      end
      if (stop) begin
        m_ph[k] = P_IDLE;
        m_pc[k] = 0;
      end else if (start) begin
        m_cnt[k] = load_val;
        m_pc[k]  = 0;
        m_ph[k]  = P_RUN;
      end else if (m_ph[k] == P_RUN && pause) begin
        m_ph[k] = P_HOLD;
      end else if (m_ph[k] == P_HOLD && !pause) begin
        m_ph[k] = P_RUN;
      end else if (m_ph[k] == P_RUN) begin
        m_pc[k]++;
        if (m_pc[k] == pres[k]) begin
          m_pc[k] = 0;
          if (m_cnt[k] == term_val) begin
            if (m_irq[k]) novr = 1'b1;
            nirq = 1'b1;
            if (mode) m_cnt[k] = load_val;
            else      m_ph[k]  = P_DONE;
          end else begin
            if (m_cnt[k] == 8'd255) m_wrap[k] = 1'b1;
            m_cnt[k] = m_cnt[k] + 8'd1;
          end
        end
      end
      m_irq[k] = nirq;
      m_ovr[k] = novr;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.count", k), cnt_o[k], m_cnt[k]);
      chk($sformatf("u%0d.busy", k), busy_o[k], (m_ph[k] == P_RUN || m_ph[k] == P_HOLD) ? 1 : 0);
      chk($sformatf("u%0d.done_irq", k), irq_o[k], m_irq[k]);
      chk($sformatf("u%0d.overrun", k), ovr_o[k], m_ovr[k]);
      chk($sformatf("u%0d.wrap", k), wrap_o[k], m_wrap[k]);
    end
  endtask

  // Advance one edge, update the model, then compare away from the edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
    irq_ack = 1'b0; load_val = 8'd0; term_val = 8'd0;
    model_reset();
    #1 reset = 1'b0;
    #11;
    compare_all();
    chk("reset.count", cnt_o[0], 0);
    chk("reset.busy", busy_o[0], 0);
    reset = 1'b1;

    // One-shot, PRESCALE=1: 0,1,2,3 then DONE with done_irq.
    mode = 1'b0; load_val = 8'd0; term_val = 8'd3; start = 1'b1;
    step();
    chk("oneshot.E0.count", cnt_o[0], 0);
    chk("oneshot.E0.busy", busy_o[0], 1);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("oneshot.E%0d.count", i), cnt_o[0], i);
    end
    step();
    chk("oneshot.E4.irq", irq_o[0], 1);
    chk("oneshot.E4.busy", busy_o[0], 0);
    chk("oneshot.E4.count", cnt_o[0], 3);
    step();
    chk("oneshot.held", cnt_o[0], 3);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;

    // Periodic with PRESCALE=4 (u_p4): 10,11,12,10,... overrun on second terminal.
    mode = 1'b1; load_val = 8'd10; term_val = 8'd12; start = 1'b1;
    step();
    chk("periodic.E0.count", cnt_o[1], 10);
    start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 3)  chk("periodic.E3.count", cnt_o[1], 10);
      if (i == 4)  chk("periodic.E4.count", cnt_o[1], 11);
      if (i == 8)  chk("periodic.E8.count", cnt_o[1], 12);
      if (i == 12) begin
        chk("periodic.E12.count", cnt_o[1], 10);
        chk("periodic.E12.irq", irq_o[1], 1);
        chk("periodic.E12.ovr", ovr_o[1], 0);
      end
      if (i == 24) chk("periodic.E24.ovr", ovr_o[1], 1);
    end

    // Ack collision on u_p1: terminal with done_irq=1 and irq_ack in the same cycle.
    stop = 1'b1; irq_ack = 1'b1;
    step();
    stop = 1'b0; irq_ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 3) begin
        chk("ack.E3.irq", irq_o[0], 1);
        chk("ack.E3.ovr", ovr_o[0], 0);
      end
    end
    irq_ack = 1'b1;
    step();
    chk("ack.collide.irq", irq_o[0], 1);
    chk("ack.collide.ovr", ovr_o[0], 1);
    chk("ack.collide.count", cnt_o[0], 10);
    step();
    chk("ack.lone.irq", irq_o[0], 0);
    chk("ack.lone.ovr", ovr_o[0], 0);

    // Wrap through all-ones with load_val > term_val.
    irq_ack = 1'b0; mode = 1'b0; load_val = 8'd254; term_val = 8'd1; start = 1'b1;
    step();
    chk("wrap.E0.count", cnt_o[0], 254);
    start = 1'b0;
    step();
    chk("wrap.E1.count", cnt_o[0], 255);
    chk("wrap.E1.wrap", wrap_o[0], 0);
    step();
    chk("wrap.E2.count", cnt_o[0], 0);
    chk("wrap.E2.wrap", wrap_o[0], 1);
    step();
    chk("wrap.E3.count", cnt_o[0], 1);
    chk("wrap.E3.wrap", wrap_o[0], 0);
    step();
    chk("wrap.E4.irq", irq_o[0], 1);
    chk("wrap.E4.busy", busy_o[0], 0);

    // Pause mid-prescale on u_p3, then stop+start together.
    mode = 1'b0; load_val = 8'd5; term_val = 8'd200; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    chk("pause.pre.count", cnt_o[2], 6);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pause.frozen.count", cnt_o[2], 6);
      chk("pause.frozen.busy", busy_o[2], 1);
    end
    pause = 1'b0;
    step();
    step();
    chk("pause.resume1.count", cnt_o[2], 6);
    step();
    chk("pause.resume2.count", cnt_o[2], 7);
    stop = 1'b1; start = 1'b1;
    step();
    chk("stopstart.count", cnt_o[2], 7);
    chk("stopstart.busy", busy_o[2], 0);
    stop = 1'b0; start = 1'b0;
    step();

    // Asynchronous reset between edges with count=7 on u_p1.
    load_val = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("areset.pre.count", cnt_o[0], 7);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("areset.count", cnt_o[0], 0);
    chk("areset.busy", busy_o[0], 0);
    chk("areset.irq", irq_o[0], 0);
    compare_all();
    #2 reset = 1'b1;
    step();
    step();
    chk("areset.idle.busy", busy_o[0], 0);
    chk("areset.idle.count", cnt_o[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
